// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite position/pop sequencer: moves the sprite diagonally, bounces it
// off the screen edges and holds the image-select bit for a number of frames.
module sprite_motion_ctrl #(
  parameter int SCREEN_W   = 1280,
  parameter int SCREEN_H   = 720,
  parameter int SPRITE_W   = 256,
  parameter int SPRITE_H   = 256,
  parameter int SPEED      = 2,
  parameter int POP_FRAMES = 30
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        enable_in,
  input  logic        pop_req_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        pop_out,
  output logic        bounce_out,
  output logic [2:0]  state_dbg_out
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WAIT   = 3'd1;
  localparam logic [2:0] MOVE_X = 3'd2;
  localparam logic [2:0] MOVE_Y = 3'd3;
  localparam logic [2:0] COMMIT = 3'd4;

  localparam int          CW       = (POP_FRAMES < 2) ? 1 : $clog2(POP_FRAMES + 1);
  localparam logic [11:0] XMAX     = 12'(SCREEN_W - SPRITE_W);
  localparam logic [11:0] XSTEP    = 12'(SPEED);
  localparam logic [10:0] YMAX     = 11'(SCREEN_H - SPRITE_H);
  localparam logic [10:0] YSTEP    = 11'(SPEED);
  localparam logic [CW-1:0] POP_LOAD = CW'(POP_FRAMES);

  logic [2:0]    state_q, state_d;
  logic          trig_q, trig_d;
  logic [10:0]   x_q, x_d, nx_q, nx_d;
  logic [9:0]    y_q, y_d, ny_q, ny_d;
  logic          dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic          flip_x_q, flip_x_d, flip_y_q, flip_y_d;
  logic          pop_q, pop_d, bounce_q, bounce_d;
  logic          pop_pend_q, pop_pend_d;
  logic [CW-1:0] pop_cnt_q, pop_cnt_d;
  logic [11:0]   x_sum;
  logic [10:0]   y_sum;

  // Outputs only move on the COMMIT edge; bounce_out is a single-cycle pulse on
  // that same edge and x/y/pop hold their value at every other edge.
  always_comb begin
    state_d    = state_q;
    trig_d     = (hcount_in == 11'd0) && (vcount_in == 10'(SCREEN_H));
    x_d        = x_q;
    y_d        = y_q;
    nx_d       = nx_q;
    ny_d       = ny_q;
    dir_x_d    = dir_x_q;
    dir_y_d    = dir_y_q;
    flip_x_d   = flip_x_q;
    flip_y_d   = flip_y_q;
    pop_d      = pop_q;
    bounce_d   = 1'b0;
    pop_pend_d = pop_pend_q | pop_req_in;
    pop_cnt_d  = pop_cnt_q;
    x_sum      = {1'b0, x_q} + XSTEP;
    y_sum      = {1'b0, y_q} + YSTEP;

    case (state_q)
      IDLE: begin
        if (enable_in) state_d = WAIT;
      end
      WAIT: begin
        if (!enable_in)  state_d = IDLE;
        else if (trig_q) state_d = MOVE_X;
      end
      MOVE_X: begin
        state_d  = MOVE_Y;
        flip_x_d = 1'b0;
        if (!dir_x_q) begin
          if (x_sum > XMAX) begin
            nx_d     = XMAX[10:0];
            flip_x_d = 1'b1;
          end else begin
            nx_d = x_sum[10:0];
          end
        end else if ({1'b0, x_q} < XSTEP) begin
          nx_d     = 11'd0;
          flip_x_d = 1'b1;
        end else begin
          nx_d = x_q - XSTEP[10:0];
        end
      end
      MOVE_Y: begin
        state_d  = COMMIT;
        flip_y_d = 1'b0;
        if (!dir_y_q) begin
          if (y_sum > YMAX) begin
            ny_d     = YMAX[9:0];
            flip_y_d = 1'b1;
          end else begin
            ny_d = y_sum[9:0];
          end
        end else if ({1'b0, y_q} < YSTEP) begin
          ny_d     = 10'd0;
          flip_y_d = 1'b1;
        end else begin
          ny_d = y_q - YSTEP[9:0];
        end
      end
      COMMIT: begin
        state_d  = WAIT;
        x_d      = nx_q;
        y_d      = ny_q;
        dir_x_d  = dir_x_q ^ flip_x_q;
        dir_y_d  = dir_y_q ^ flip_y_q;
        bounce_d = flip_x_q | flip_y_q;
        // A request landing on this very edge is kept for the next frame.
        pop_pend_d = pop_req_in;
        if (pop_pend_q) begin
          pop_cnt_d = POP_LOAD;
          pop_d     = 1'b1;
        end else if (pop_cnt_q != '0) begin
          pop_cnt_d = pop_cnt_q - CW'(1);
          pop_d     = (pop_cnt_q != CW'(1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      trig_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      nx_q       <= '0;
      ny_q       <= '0;
      dir_x_q    <= 1'b0;
      dir_y_q    <= 1'b0;
      flip_x_q   <= 1'b0;
      flip_y_q   <= 1'b0;
      pop_q      <= 1'b0;
      bounce_q   <= 1'b0;
      pop_pend_q <= 1'b0;
      pop_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      trig_q     <= trig_d;
      x_q        <= x_d;
      y_q        <= y_d;
      nx_q       <= nx_d;
      ny_q       <= ny_d;
      dir_x_q    <= dir_x_d;
      dir_y_q    <= dir_y_d;
      flip_x_q   <= flip_x_d;
      flip_y_q   <= flip_y_d;
      pop_q      <= pop_d;
      bounce_q   <= bounce_d;
      pop_pend_q <= pop_pend_d;
      pop_cnt_q  <= pop_cnt_d;
    end
  end

  assign x_out         = x_q;
  assign y_out         = y_q;
  assign pop_out       = pop_q;
  assign bounce_out    = bounce_q;
  assign state_dbg_out = state_q;

endmodule
